// File: rtl/time_counter.sv
// mm:ss time source for a four-digit seven-segment display stage.
// Each BCD digit has its own 5-bit bus and a one-cycle update strobe that rises one cycle after the digit changes.
module time_counter #(
    parameter int CLK_FREQ = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       clear,
    output logic [4:0] s1_counter,
    output logic [4:0] s10_counter,
    output logic [4:0] m1_counter,
    output logic [4:0] m10_counter,
    output logic       s1_bit,
    output logic       s10_bit,
    output logic       m1_bit,
    output logic       m10_bit
);

    localparam int PW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] TERM = PW'(CLK_FREQ - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    s1_q, s1_d, s10_q, s10_d, m1_q, m1_d, m10_q, m10_d;
    logic [3:0]    chg_q, chg_d;
    logic [3:0]    strobe_q, strobe_d;
    logic          clr_q, clr_d;
    logic          init_q;
    logic          tick_s, c0_s, c1_s, c2_s;

    assign tick_s = run && (presc_q == TERM);
    assign c0_s   = tick_s && (s1_q == 4'd9);
    assign c1_s   = c0_s && (s10_q == 4'd5);
    assign c2_s   = c1_s && (m1_q == 4'd9);

    // Next-state: prescaler, digit cascade, change detection and strobe scheduling.
    // Strobes lag the digit change by one cycle (chg_q stage) so each bus is settled before its strobe rises;
    // a held clear re-arms the all-digit request only every other cycle so the strobes keep producing edges.
    always_comb begin
        presc_d  = presc_q;
        s1_d     = s1_q;
        s10_d    = s10_q;
        m1_d     = m1_q;
        m10_d    = m10_q;
        chg_d    = 4'b0000;
        clr_d    = 1'b0;
        strobe_d = 4'b0000;
        if (clear) begin
            presc_d = '0;
            s1_d    = 4'd0;
            s10_d   = 4'd0;
            m1_d    = 4'd0;
            m10_d   = 4'd0;
            chg_d   = {4{~clr_q}};
            clr_d   = ~clr_q;
        end else begin
            if (run) begin
                presc_d = tick_s ? '0 : presc_q + PW'(1);
            end else begin
                presc_d = presc_q;
            end
            s1_d  = tick_s ? (c0_s ? 4'd0 : s1_q + 4'd1)  : s1_q;
            s10_d = c0_s   ? (c1_s ? 4'd0 : s10_q + 4'd1) : s10_q;
            m1_d  = c1_s   ? (c2_s ? 4'd0 : m1_q + 4'd1)  : m1_q;
            m10_d = c2_s   ? ((m10_q == 4'd5) ? 4'd0 : m10_q + 4'd1) : m10_q;
            chg_d = {m10_d != m10_q, m1_d != m1_q, s10_d != s10_q, s1_d != s1_q};
            clr_d = 1'b0;
        end
        if (init_q) begin
            strobe_d = 4'b1111;
        end else begin
            strobe_d = chg_q;
        end
    end

    // State registers; reset clears everything and arms the initial all-digit strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            s1_q     <= 4'd0;
            s10_q    <= 4'd0;
            m1_q     <= 4'd0;
            m10_q    <= 4'd0;
            chg_q    <= 4'b0000;
            strobe_q <= 4'b0000;
            clr_q    <= 1'b0;
            init_q   <= 1'b1;
        end else begin
            presc_q  <= presc_d;
            s1_q     <= s1_d;
            s10_q    <= s10_d;
            m1_q     <= m1_d;
            m10_q    <= m10_d;
            chg_q    <= chg_d;
            strobe_q <= strobe_d;
            clr_q    <= clr_d;
            init_q   <= 1'b0;
        end
    end

    assign s1_counter  = {1'b0, s1_q};
    assign s10_counter = {1'b0, s10_q};
    assign m1_counter  = {1'b0, m1_q};
    assign m10_counter = {1'b0, m10_q};
    assign s1_bit      = strobe_q[0];
    assign s10_bit     = strobe_q[1];
    assign m1_bit      = strobe_q[2];
    assign m10_bit     = strobe_q[3];

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter with CLK_FREQ=4: vector table for init/hold/clear, plus hand sequences
// for counting, carries, 59:59 wrap, clear-with-tick and asynchronous reset.
module tb_time_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       clear = 1'b0;
    logic [4:0] s1_counter, s10_counter, m1_counter, m10_counter;
    logic       s1_bit, s10_bit, m1_bit, m10_bit;

    int n_tests = 0;
    int n_fail  = 0;

    time_counter #(.CLK_FREQ(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .clear(clear),
        .s1_counter(s1_counter), .s10_counter(s10_counter),
        .m1_counter(m1_counter), .m10_counter(m10_counter),
        .s1_bit(s1_bit), .s10_bit(s10_bit), .m1_bit(m1_bit), .m10_bit(m10_bit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic        clear;
        logic [15:0] exp_dig;
        logic [3:0]  exp_bits;
    } vec_t;

    function automatic vec_t mk(logic r, logic c, logic [15:0] d, logic [3:0] b);
        vec_t v;
        v.run = r; v.clear = c; v.exp_dig = d; v.exp_bits = b;
        return v;
    endfunction

    function automatic logic [19:0] wide(logic [15:0] d);
        return {1'b0, d[15:12], 1'b0, d[11:8], 1'b0, d[7:4], 1'b0, d[3:0]};
    endfunction

    function automatic logic [19:0] act_dig();
        return {m10_counter, m1_counter, s10_counter, s1_counter};
    endfunction

    function automatic logic [3:0] act_bits();
        return {m10_bit, m1_bit, s10_bit, s1_bit};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic c);
        run = r;
        clear = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_and_settle();
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
    endtask

    vec_t vecs[22];

    initial begin
        logic [3:0] seen;
        int s1_pulses, s10_pulses, seq_err;
        logic [3:0] exp_s1;
        logic [3:0] win_exp[6];

        // Vectors from reset release: init strobe, hold, counting, hold mid-period, clear, held clear.
        vecs[0]  = mk(1'b0, 1'b0, 16'h0000, 4'hF);
        vecs[1]  = mk(1'b0, 1'b0, 16'h0000, 4'h0);
        vecs[2]  = mk(1'b0, 1'b0, 16'h0000, 4'h0);
        vecs[3]  = mk(1'b1, 1'b0, 16'h0000, 4'h0);
        vecs[4]  = mk(1'b1, 1'b0, 16'h0000, 4'h0);
        vecs[5]  = mk(1'b1, 1'b0, 16'h0000, 4'h0);
        vecs[6]  = mk(1'b1, 1'b0, 16'h0001, 4'h0);
        vecs[7]  = mk(1'b1, 1'b0, 16'h0001, 4'h1);
        vecs[8]  = mk(1'b0, 1'b0, 16'h0001, 4'h0);
        vecs[9]  = mk(1'b0, 1'b0, 16'h0001, 4'h0);
        vecs[10] = mk(1'b1, 1'b0, 16'h0001, 4'h0);
        vecs[11] = mk(1'b1, 1'b0, 16'h0001, 4'h0);
        vecs[12] = mk(1'b1, 1'b0, 16'h0002, 4'h0);
        vecs[13] = mk(1'b1, 1'b0, 16'h0002, 4'h1);
        vecs[14] = mk(1'b1, 1'b1, 16'h0000, 4'h0);
        vecs[15] = mk(1'b0, 1'b0, 16'h0000, 4'hF);
        vecs[16] = mk(1'b0, 1'b1, 16'h0000, 4'h0);
        vecs[17] = mk(1'b0, 1'b1, 16'h0000, 4'hF);
        vecs[18] = mk(1'b0, 1'b1, 16'h0000, 4'h0);
        vecs[19] = mk(1'b0, 1'b1, 16'h0000, 4'hF);
        vecs[20] = mk(1'b0, 1'b0, 16'h0000, 4'h0);
        vecs[21] = mk(1'b0, 1'b0, 16'h0000, 4'h0);

        repeat (3) @(negedge clk);
        chk("reset_digits", 32'(act_dig()), 32'(wide(16'h0000)));
        chk("reset_bits", 32'(act_bits()), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            step(vecs[i].run, vecs[i].clear);
            chk($sformatf("vec%0d_digits", i), 32'(act_dig()), 32'(wide(vecs[i].exp_dig)));
            chk($sformatf("vec%0d_bits", i), 32'(act_bits()), 32'(vecs[i].exp_bits));
        end

        // Hold with prescaler at 2: next tick lands 2 edges after run rises; no strobes while held.
        clear_and_settle();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        seen = 4'h0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            seen |= act_bits();
        end
        chk("hold_no_strobe", 32'(seen), 32'h0);
        step(1'b1, 1'b0);
        chk("hold_resume1_s1", 32'(s1_counter), 32'd0);
        step(1'b1, 1'b0);
        chk("hold_resume2_s1", 32'(s1_counter), 32'd1);
        step(1'b0, 1'b0);
        chk("hold_resume_strobe", 32'(act_bits()), 32'h1);

        // 40 counting edges: ten s1 strobes, s1 stepping 1..9,0, s10 strobe together with the wrap.
        clear_and_settle();
        s1_pulses = 0; s10_pulses = 0; seq_err = 0; exp_s1 = 4'd0;
        for (int i = 0; i < 41; i++) begin
            step((i < 40) ? 1'b1 : 1'b0, 1'b0);
            if (s1_bit) begin
                s1_pulses++;
                exp_s1 = (exp_s1 == 4'd9) ? 4'd0 : exp_s1 + 4'd1;
                if (s1_counter !== {1'b0, exp_s1}) seq_err++;
            end
            if (s10_bit) begin
                s10_pulses++;
                if (!s1_bit || s10_counter !== 5'd1 || s1_counter !== 5'd0) seq_err++;
            end
        end
        chk("count_s1_pulses", 32'(s1_pulses), 32'd10);
        chk("count_s10_pulses", 32'(s10_pulses), 32'd1);
        chk("count_sequence_errs", 32'(seq_err), 32'd0);
        chk("count_final", 32'(act_dig()), 32'(wide(16'h0010)));

        // Reach 12:34 with the prescaler at its terminal count, then clear on the tick cycle.
        clear_and_settle();
        repeat (3019) step(1'b1, 1'b0);
        chk("preload_1234", 32'(act_dig()), 32'(wide(16'h1234)));
        step(1'b1, 1'b1);
        chk("clr_tick_digits", 32'(act_dig()), 32'(wide(16'h0000)));
        chk("clr_tick_bits0", 32'(act_bits()), 32'h0);
        step(1'b1, 1'b0);
        chk("clr_tick_bits1", 32'(act_bits()), 32'hF);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("clr_presc_restart_s1", 32'(s1_counter), 32'd0);
        step(1'b1, 1'b0);
        chk("clr_presc_first_tick", 32'(s1_counter), 32'd1);

        // 3599 ticks to 59:59, then the wrap to 00:00 with a single all-digit strobe.
        clear_and_settle();
        repeat (14397) step(1'b1, 1'b0);
        chk("preload_5959", 32'(act_dig()), 32'(wide(16'h5959)));
        win_exp[0] = 4'h0; win_exp[1] = 4'h0; win_exp[2] = 4'h0;
        win_exp[3] = 4'hF; win_exp[4] = 4'h0; win_exp[5] = 4'h0;
        seq_err = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0);
            if (act_bits() !== win_exp[i]) seq_err++;
        end
        chk("wrap_strobe_window_errs", 32'(seq_err), 32'd0);
        chk("wrap_digits", 32'(act_dig()), 32'(wide(16'h0000)));

        // Asynchronous reset while the s1 strobe is high.
        clear_and_settle();
        repeat (5) step(1'b1, 1'b0);
        chk("pre_areset_bits", 32'(act_bits()), 32'h1);
        chk("pre_areset_s1", 32'(s1_counter), 32'd1);
        run = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("areset_bits", 32'(act_bits()), 32'h0);
        chk("areset_digits", 32'(act_dig()), 32'(wide(16'h0000)));
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0);
        chk("rerelease_init_bits", 32'(act_bits()), 32'hF);
        chk("rerelease_digits", 32'(act_dig()), 32'(wide(16'h0000)));
        step(1'b0, 1'b0);
        chk("rerelease_bits_low", 32'(act_bits()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
